// File: rtl/if_fetch_master.sv
// Instruction-fetch initiator: owns the PC, holds each ce/addr request until acked, and
// registers the returned instruction into IF/ID. Handles stall, flush, delay-slot branches, timeout.
module if_fetch_master #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        rom_ack_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        fetch_stall_req_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {StIdle, StWait, StErr} state_t;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_if_pc;
    logic [31:0]       r_if_inst;
    logic              r_if_valid;
    logic              r_err;
    logic              r_pend;
    logic [31:0]       r_pend_target;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_wait;
    logic              w_accept;
    logic [31:0]       w_next_pc;
    logic              w_misalign;

    assign w_wait     = (r_state == StWait);
    assign w_accept   = w_wait & rom_ack_i & ~stall_i & ~flush_i;
    assign w_next_pc  = branch_flag_i ? branch_target_i :
                        r_pend        ? r_pend_target   : r_pc + 32'd4;
    assign w_misalign = |w_next_pc[1:0];

    assign rom_ce_o          = w_wait;
    assign rom_addr_o        = r_pc;
    assign if_pc_o           = r_if_pc;
    assign if_inst_o         = r_if_inst;
    assign if_valid_o        = r_if_valid;
    assign fetch_err_o       = r_err;
    assign fetch_stall_req_o = w_wait & ~rom_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_if_pc       <= 32'd0;
            r_if_inst     <= 32'd0;
            r_if_valid    <= 1'b0;
            r_err         <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_target <= 32'd0;
            r_cnt         <= '0;
        end else if (flush_i && r_state != StErr) begin
            // Any ack in this cycle belongs to the squashed path and is dropped.
            if (|new_pc_i[1:0]) begin
                r_state <= StErr;
                r_err   <= 1'b1;
            end else begin
                r_pc    <= new_pc_i;
                r_state <= StWait;
            end
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'd0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                StIdle: r_state <= StWait;
                StWait: begin
                    if (w_accept) begin
                        r_if_inst  <= rom_inst_i;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_pend     <= 1'b0;
                        if (w_misalign) begin
                            r_state    <= StErr;
                            r_err      <= 1'b1;
                            r_if_valid <= 1'b0;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end else if (!stall_i) begin
                        // Branch seen before the delay slot arrived: redirect after it.
                        if (branch_flag_i) begin
                            r_pend        <= 1'b1;
                            r_pend_target <= branch_target_i;
                        end
                        if (!rom_ack_i) begin
                            if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                                r_state    <= StErr;
                                r_err      <= 1'b1;
                                r_if_valid <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_master.md
Name: if_fetch_master

Overview:
- Instruction-fetch initiator: the requesting end of the instruction-memory ce/addr → inst/ack handshake.
- Owns the PC.
- Holds each request stable until the memory acknowledges it, then registers the instruction and its PC into the IF/ID path.
- Handles pipeline stall, flush, MIPS branches with a delay slot, and a no-ack timeout.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
TIMEOUT, 16, consecutive unstalled WAIT cycles without ack before error
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  pipeline stall for IF stage
flush_i  in  1  exception flush
new_pc_i  in  32  flush target
branch_flag_i  in  1  branch taken (one-cycle pulse from ID)
branch_target_i  in  32  branch target
rom_ce_o  out  1  memory request / chip enable
rom_addr_o  out  32  fetch address
rom_inst_i  in  32  returned instruction
rom_ack_i  in  1  memory acknowledge
if_pc_o  out  32  PC of delivered instruction
if_inst_o  out  32  delivered instruction
if_valid_o  out  1  if_inst_o is valid
fetch_stall_req_o  out  1  stall request while memory is busy
fetch_err_o  out  1  sticky fetch error

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC. All registered outputs are 0: rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o, fetch_err_o. Pending branch cleared, counter cleared.
- rom_addr_o is the pc register. rom_ce_o=1 exactly when state=WAIT.
- States:
  - IDLE: unconditional → WAIT next clock. First request appears 1 cycle after rst falls.
  - WAIT: request driven; ce and addr never change while waiting.
  - ERR: ce=0, terminal until rst.
- Accept A = WAIT & rom_ack_i & !stall_i & !flush_i.
- On A:
  - if_inst_o<=rom_inst_i, if_pc_o<=pc, if_valid_o<=1, counter<=0.
  - Next pc, in priority order: branch_flag_i → branch_target_i; else pending → pend_target (clear pending); else pc+4.
  - With a zero-wait memory this gives back-to-back fetches, 1 instruction/clock.
- Delay slot: the instruction accepted in the same cycle as branch_flag_i is the delay slot and stays valid.
  - branch_flag_i with stall_i=0 and no A: record pending=1, pend_target=branch_target_i.
  - The next accepted fetch (the delay slot) redirects to pend_target.
  - A second branch while pending overwrites pend_target.
- stall_i=1 (no flush):
  - ack ignored; request held; if_* held; counter frozen.
  - branch_flag_i ignored (ID re-presents it after the stall).
- Priority: rst > flush_i > branch/A > stall_i.
- flush_i=1 (any state except ERR): pc<=new_pc_i, if_valid_o<=0, if_inst_o<=0, pending cleared, counter cleared, state=WAIT. An ack in the flush cycle is discarded.
- No ack: fetch_stall_req_o = WAIT & !rom_ack_i (combinational; 0 in IDLE/ERR).
- While if_* are not updated (no A, no flush), if_valid_o holds its value. ID consumes it under stall control.
- Timeout: counter increments each WAIT cycle with !ack & !stall_i. When counter reaches TIMEOUT-1 and another such cycle occurs: state=ERR, fetch_err_o=1, if_valid_o=0. Counter saturates and never wraps.
- Misalignment: a branch_target_i, new_pc_i or pend_target with [1:0]!=0, when it would be loaded into pc, → ERR, fetch_err_o=1. pc keeps its old value.
- pc+4 wraps 32'hFFFFFFFC → 32'h00000000 silently.
- Reset mid-request: ce drops immediately (async). The outstanding ack is irrelevant.

Test Plan:
- Release rst with ack tied 1 and rom_inst_i=addr^32'hA5A5A5A5 → ce=1 one clock after release. rom_addr 0,4,8,C on consecutive clocks. if_pc_o/if_inst_o follow one clock later with if_valid_o=1.
- Ack delayed 3 cycles on addr 4 → rom_addr_o stays 4 and ce stays 1 for 3 cycles. fetch_stall_req_o=1 for those cycles. Exactly one capture of addr 4, then addr 8.
- Two cases, each checking the delay slot is delivered valid:
  - branch_flag_i with target 32'h100 in the cycle addr 8 is accepted → next rom_addr_o=32'h100, delay slot addr 8 valid.
  - Same pulse while addr 8 is still waiting → addr 8 delivered valid, then 32'h100.
- stall_i=1 for 4 cycles with ack=1 at addr 0xC → if_* unchanged, addr 0xC held. After release, 0xC captured once.
- flush_i with new_pc_i=32'h180 during a wait → if_valid_o=0 next clock, rom_addr_o=32'h180. A simultaneous ack is not captured.
- Ack never returns with TIMEOUT=16 → fetch_err_o=1 after exactly 16 unstalled WAIT cycles, ce=0. Branch to 32'h102 → ERR with pc unchanged.
